sys_cmd_master: RTL and testbench

//  Host-side initiator for the system command protocol: turns one request (RF write/read, ALU with/without operands)

---
 rtl/sys_cmd_master.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_sys_cmd_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_master.sv
// Host-side initiator for the system command protocol: serialises one request into a
// command byte frame over a UART TX byte interface and collects the response from UART RX.
module sys_cmd_master #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [3:0]  req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [7:0]  req_op_a,
  input  logic [7:0]  req_op_b,
  input  logic [3:0]  req_fun,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout
);

  localparam logic [1:0] CMD_RF_WR   = 2'b00;
  localparam logic [1:0] CMD_RF_RD   = 2'b01;
  localparam logic [1:0] CMD_ALU_OP  = 2'b10;
  localparam logic [1:0] CMD_ALU_NOP = 2'b11;

  localparam logic [TO_W-1:0] TERM_CNT = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_GAP     = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Byte at position idx of the frame for the given command.
  function automatic logic [7:0] frame_byte(
    input logic [1:0] cmd,
    input logic [2:0] idx,
    input logic [3:0] addr,
    input logic [7:0] wdata,
    input logic [7:0] op_a,
    input logic [7:0] op_b,
    input logic [3:0] fun
  );
    logic [7:0] b;
    b = 8'h00;
    case (cmd)
      CMD_RF_WR: begin
        case (idx)
          3'd0:    b = 8'hAA;
          3'd1:    b = {4'h0, addr};
          default: b = wdata;
        endcase
      end
      CMD_RF_RD: begin
        case (idx)
          3'd0:    b = 8'hBB;
          default: b = {4'h0, addr};
        endcase
      end
      CMD_ALU_OP: begin
        case (idx)
          3'd0:    b = 8'hCC;
          3'd1:    b = op_a;
          3'd2:    b = op_b;
          default: b = {4'h0, fun};
        endcase
      end
      default: begin
        case (idx)
          3'd0:    b = 8'hDD;
          default: b = {4'h0, fun};
        endcase
      end
    endcase
    return b;
  endfunction

  function automatic logic [2:0] frame_len(input logic [1:0] cmd);
    logic [2:0] n;
    case (cmd)
      CMD_RF_WR:  n = 3'd3;
      CMD_RF_RD:  n = 3'd2;
      CMD_ALU_OP: n = 3'd4;
      default:    n = 3'd2;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] rsp_len(input logic [1:0] cmd);
    logic [1:0] n;
    case (cmd)
      CMD_RF_WR: n = 2'd0;
      CMD_RF_RD: n = 2'd1;
      default:   n = 2'd2;
    endcase
    return n;
  endfunction

  state_e          state_q,       state_d;
  logic [2:0]      idx_q,         idx_d;
  logic [1:0]      cmd_q,         cmd_d;
  logic [3:0]      addr_q,        addr_d;
  logic [7:0]      wdata_q,       wdata_d;
  logic [7:0]      op_a_q,        op_a_d;
  logic [7:0]      op_b_q,        op_b_d;
  logic [3:0]      fun_q,         fun_d;
  logic [TO_W-1:0] cnt_q,         cnt_d;
  logic [7:0]      lo_q,          lo_d;
  logic [7:0]      hi_q,          hi_d;
  logic [7:0]      tx_data_q,     tx_data_d;
  logic            tx_valid_q,    tx_valid_d;
  logic            req_ready_q,   req_ready_d;
  logic            rsp_valid_q,   rsp_valid_d;
  logic [15:0]     rsp_data_q,    rsp_data_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    fun_d         = fun_q;
    cnt_d         = cnt_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          cmd_d      = req_cmd;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          op_a_d     = req_op_a;
          op_b_d     = req_op_b;
          fun_d      = req_fun;
          lo_d       = 8'h00;
          hi_d       = 8'h00;
          idx_d      = 3'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(req_cmd, 3'd0, req_addr, req_wdata, req_op_a, req_op_b, req_fun);
          state_d    = S_SEND;
        end else begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end

      S_SEND: begin
        if (tx_valid_q && !tx_busy) begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          idx_d      = idx_q + 3'd1;
          state_d    = S_GAP;
        end else begin
          state_d = S_SEND;
        end
      end

      // One idle cycle after each byte so the UART can raise busy before the next one.
      S_GAP: begin
        if (idx_q == frame_len(cmd_q)) begin
          cnt_d = '0;
          if (rsp_len(cmd_q) == 2'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_LO;
          end
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(cmd_q, idx_q, addr_q, wdata_q, op_a_q, op_b_q, fun_q);
          state_d    = S_SEND;
        end
      end

      // A byte arriving on the terminal-count cycle takes priority over the timeout.
      S_WAIT_LO: begin
        if (rx_valid) begin
          lo_d  = rx_data;
          cnt_d = '0;
          if (rsp_len(cmd_q) == 2'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_HI;
          end
        end else if (cnt_q == TERM_CNT) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_WAIT_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == TERM_CNT) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_DONE: begin
        rsp_valid_d = 1'b1;
        case (cmd_q)
          CMD_RF_WR: rsp_data_d = 16'h0000;
          CMD_RF_RD: rsp_data_d = {8'h00, lo_q};
          default:   rsp_data_d = {hi_q, lo_q};
        endcase
        state_d = S_IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        state_d    = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 3'd0;
      cmd_q         <= 2'b00;
      addr_q        <= 4'h0;
      wdata_q       <= 8'h00;
      op_a_q        <= 8'h00;
      op_b_q        <= 8'h00;
      fun_q         <= 4'h0;
      cnt_q         <= '0;
      lo_q          <= 8'h00;
      hi_q          <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 16'h0000;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      fun_q         <= fun_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Table-driven bench for sys_cmd_master: expected TX bytes and responses are queued at
// request time and compared by a monitor as the DUT produces them.
module tb_sys_cmd_master;

  localparam int TO_CYC = 16;
  localparam int TO_W   = 5;

  logic        Clk, Rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_cmd;
  logic [3:0]  req_addr, req_fun;
  logic [7:0]  req_wdata, req_op_a, req_op_b;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_busy, rx_valid;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_data;

  sys_cmd_master #(.TIMEOUT_CYC(TO_CYC), .TO_W(TO_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_op_a(req_op_a),
    .req_op_b(req_op_b), .req_fun(req_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] cmd;
    logic [3:0] addr;
    logic [7:0] wdata, a, b;
    logic [3:0] fun;
    int         busy;
    int         nrx;
    logic [7:0] lo, hi;
    int         hi_delay;
    bit         stray;
    bit         reject;
    bit         exp_to;
    int         exp_lat;
  } vec_t;

  typedef struct {
    bit          to;
    logic [15:0] data;
  } rsp_t;

  vec_t        vecs[8];
  logic [7:0]  txq[$];
  rsp_t        rspq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          busy_len = 0;
  logic [15:0] last_rsp = 16'h0000;

  logic        prev_valid = 1'b0;
  logic        prev_xfer = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        mon_xfer;
  logic [7:0]  mon_byte;
  rsp_t        mon_rsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic send_rx(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic vec_t mk(input logic [1:0] cmd, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] fun, input int busy,
                              input int nrx, input logic [7:0] lo, input logic [7:0] hi,
                              input int hd, input bit stray, input bit rej, input bit to,
                              input int lat);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.a = a; v.b = b; v.fun = fun;
    v.busy = busy; v.nrx = nrx; v.lo = lo; v.hi = hi; v.hi_delay = hd;
    v.stray = stray; v.reject = rej; v.exp_to = to; v.exp_lat = lat;
    return v;
  endfunction

  // UART TX model: holds busy for busy_len cycles after each byte is presented.
  initial begin
    int bc;
    bc = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (tx_valid === 1'b1 && bc < busy_len) begin
        tx_busy = 1'b1;
        bc++;
      end else begin
        tx_busy = 1'b0;
        if (tx_valid !== 1'b1) bc = 0;
      end
    end
  end

  // Monitor: TX handshake rules and scoreboard pops, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      mon_xfer = (tx_valid === 1'b1) && (tx_busy === 1'b0);
      if (tx_valid !== 1'b1) chk("tx_data_idle_zero", {24'h0, tx_data}, 32'h0);
      if (prev_xfer) begin
        chk("gap_after_transfer", {31'h0, tx_valid}, 32'h0);
      end else if (prev_valid) begin
        chk("tx_valid_held", {31'h0, tx_valid}, 32'h1);
        chk("tx_data_held", {24'h0, tx_data}, {24'h0, prev_data});
      end
      if (mon_xfer) begin
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %02h expected no byte (t=%0t)", tx_data, $time);
        end else begin
          mon_byte = txq.pop_front();
          chk("tx_byte", {24'h0, tx_data}, {24'h0, mon_byte});
        end
      end
      if (rsp_valid === 1'b1 || rsp_timeout === 1'b1) begin
        if (rspq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got valid=%0b timeout=%0b expected no pulse", rsp_valid, rsp_timeout);
        end else begin
          mon_rsp = rspq.pop_front();
          chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, mon_rsp.to});
          chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, !mon_rsp.to});
          chk("rsp_data", {16'h0, rsp_data}, {16'h0, mon_rsp.data});
        end
      end
      prev_valid = (tx_valid === 1'b1);
      prev_xfer  = mon_xfer;
      prev_data  = tx_data;
    end else begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end
  end

  task automatic push_frame(input vec_t v);
    case (v.cmd)
      2'b00: begin txq.push_back(8'hAA); txq.push_back({4'h0, v.addr}); txq.push_back(v.wdata); end
      2'b01: begin txq.push_back(8'hBB); txq.push_back({4'h0, v.addr}); end
      2'b10: begin
        txq.push_back(8'hCC); txq.push_back(v.a); txq.push_back(v.b); txq.push_back({4'h0, v.fun});
      end
      default: begin txq.push_back(8'hDD); txq.push_back({4'h0, v.fun}); end
    endcase
  endtask

  task automatic run(input vec_t v);
    int   guard;
    int   acc;
    rsp_t e;
    busy_len = v.busy;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    chk("req_ready_before", {31'h0, req_ready}, 32'h1);
    req_cmd = v.cmd; req_addr = v.addr; req_wdata = v.wdata;
    req_op_a = v.a; req_op_b = v.b; req_fun = v.fun;
    req_valid = 1'b1;
    push_frame(v);
    e.to = v.exp_to;
    if (v.exp_to) begin
      e.data = last_rsp;
    end else begin
      case (v.cmd)
        2'b00:   e.data = 16'h0000;
        2'b01:   e.data = {8'h00, v.lo};
        default: e.data = {v.hi, v.lo};
      endcase
      last_rsp = e.data;
    end
    rspq.push_back(e);
    tick();
    acc = cyc;
    req_valid = 1'b0;
    if (v.reject) begin
      req_cmd = ~v.cmd; req_addr = 4'hE; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
    end
    if (v.stray) send_rx(8'hEE);
    guard = 0;
    while (txq.size() != 0 && guard < 500) begin tick(); guard++; end
    chk("frame_complete", txq.size(), 32'h0);
    if (v.nrx >= 1) begin tick(); send_rx(v.lo); end
    if (v.nrx >= 2) begin repeat (v.hi_delay) tick(); send_rx(v.hi); end
    guard = 0;
    while (!(rsp_valid === 1'b1 || rsp_timeout === 1'b1) && guard < 200) begin tick(); guard++; end
    chk("rsp_pulse_seen", {31'h0, (rsp_valid === 1'b1) || (rsp_timeout === 1'b1)}, 32'h1);
    if (v.exp_lat != 0) chk("latency", cyc - acc, v.exp_lat);
    chk("req_ready_after", {31'h0, req_ready}, 32'h1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_addr = 4'h0; req_wdata = 8'h00;
    req_op_a = 8'h00; req_op_b = 8'h00; req_fun = 4'h0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (2) tick();
    chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
    chk("reset_rsp_data", {16'h0, rsp_data}, 32'h0);
    Rst = 1'b1;
    tick();

    //           cmd    addr   wdata  a      b      fun   busy nrx lo     hi     hd st rj to lat
    vecs[0] = mk(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 7);
    vecs[1] = mk(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 8'h5A, 8'h00, 1, 1, 0, 0, 6);
    vecs[2] = mk(2'b10, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0, 5, 2, 8'h30, 8'h00, 1, 0, 0, 0, 0);
    vecs[3] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0, 1, 8'h7F, 8'h00, 1, 0, 0, 1, 21);
    vecs[4] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h9, 0, 2, 8'h34, 8'h12, 15, 0, 0, 0, 22);
    vecs[5] = mk(2'b00, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0, 2, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    vecs[6] = mk(2'b01, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, 1, 1, 8'h81, 8'h00, 1, 0, 1, 0, 0);
    vecs[7] = mk(2'b10, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, 0, 2, 8'hAB, 8'hCD, 1, 1, 0, 0, 12);

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Reset while the second byte of an RF write is on the wire: silent abort.
    busy_len = 0;
    req_cmd = 2'b00; req_addr = 4'h1; req_wdata = 8'h02; req_valid = 1'b1;
    txq.push_back(8'hAA);
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    chk("mid_send_tx_valid", {31'h0, tx_valid}, 32'h1);
    Rst = 1'b0;
    tick();
    chk("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_reset_rsp_data", {16'h0, rsp_data}, 32'h0);
    chk("mid_reset_aa_sent", txq.size(), 32'h0);
    txq.delete();
    last_rsp = 16'h0000;
    Rst = 1'b1;
    repeat (12) tick();
    chk("no_pulse_after_abort", rspq.size(), 32'h0);

    run(mk(2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 8'hC3, 8'h00, 1, 0, 0, 0, 6));
    repeat (3) tick();
    chk("scoreboard_drained", txq.size() + rspq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
